// File: rtl/stall_scheduler_if.sv
// rtl/stall_scheduler_if.sv - stall request / grant bundle between requesters and the stall scheduler
interface stall_scheduler_if;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_vec;
   logic       stall;
   logic       timeout;

   // Requester / pipeline side: drives enable, requests and done; observes grant.
   modport master (
      output en,
      output req,
      output done,
      input  gnt_valid,
      input  gnt_idx,
      input  gnt_vec,
      input  stall,
      input  timeout
   );

   // Scheduler side.
   modport slave (
      input  en,
      input  req,
      input  done,
      output gnt_valid,
      output gnt_idx,
      output gnt_vec,
      output stall,
      output timeout
   );
endinterface

// File: rtl/stall_scheduler.sv
// rtl/stall_scheduler.sv - fixed-priority stall arbiter holding a registered grant with timeout
module stall_scheduler #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   stall_scheduler_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Counter value seen on the last permitted GRANT cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q,     state_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [2:0]       gnt_idx_q,   gnt_idx_d;
   logic [7:0]       gnt_vec_q,   gnt_vec_d;
   logic             timeout_q,   timeout_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   logic [2:0]       pick_idx;
   logic             req_any;
   logic             owner_req;

   // Lowest set bit wins; bit 0 is the highest-priority requester.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) begin
            r = 3'(i);
         end
      end
      return r;
   endfunction

   assign req_any   = |bus.req;
   assign pick_idx  = lowest_set(bus.req);
   assign owner_req = bus.req[gnt_idx_q];

   // Next-state and registered-output selection; exits from GRANT are checked in priority order.
   always_comb begin
      state_d     = state_q;
      gnt_valid_d = gnt_valid_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_vec_d   = gnt_vec_q;
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.en && req_any) begin
               state_d     = GRANT;
               gnt_valid_d = 1'b1;
               gnt_idx_d   = pick_idx;
               gnt_vec_d   = 8'd1 << pick_idx;
            end
         end

         GRANT: begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (!bus.en) begin
               // Abort: straight back to IDLE, no turnaround, no timeout pulse.
               state_d     = IDLE;
               gnt_valid_d = 1'b0;
               gnt_vec_d   = 8'h00;
               cnt_d       = '0;
            end else if (bus.done || !owner_req) begin
               state_d     = GAP;
               gnt_valid_d = 1'b0;
               gnt_vec_d   = 8'h00;
               cnt_d       = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = GAP;
               gnt_valid_d = 1'b0;
               gnt_vec_d   = 8'h00;
               cnt_d       = '0;
               timeout_d   = 1'b1;
            end
         end

         GAP: begin
            // One turnaround cycle; done and requests are ignored here.
            state_d = IDLE;
            cnt_d   = '0;
         end

         default: begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
            gnt_vec_d   = 8'h00;
            cnt_d       = '0;
         end
      endcase
   end

   // State, grant outputs and duration counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= 3'd0;
         gnt_vec_q   <= 8'h00;
         timeout_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_vec_q   <= gnt_vec_d;
         timeout_q   <= timeout_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.gnt_valid = gnt_valid_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.gnt_vec   = gnt_vec_q;
   assign bus.timeout   = timeout_q;
   // Stall covers the request window, ownership and the turnaround cycle.
   assign bus.stall     = (state_q == GRANT) | (state_q == GAP) | (bus.en & req_any);

endmodule

// File: tb/tb_stall_scheduler.sv
// tb/tb_stall_scheduler.sv - directed table-driven bench for stall_scheduler
module tb_stall_scheduler;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   stall_scheduler_if bus ();

   stall_scheduler #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic       en;
      logic [7:0] req;
      logic       done;
      logic       ev;
      logic [2:0] ei;
      logic [7:0] evec;
      logic       es;
      logic       et;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic add(input string nm, input logic en, input logic [7:0] req, input logic done,
                      input logic ev, input logic [2:0] ei, input logic [7:0] evec,
                      input logic es, input logic et);
      vec_t v;
      v.nm = nm; v.en = en; v.req = req; v.done = done;
      v.ev = ev; v.ei = ei; v.evec = evec; v.es = es; v.et = et;
      tbl.push_back(v);
   endtask

   task automatic check_outs(input string nm, input logic ev, input logic [2:0] ei,
                             input logic [7:0] evec, input logic es, input logic et);
      chk({nm, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(ev));
      chk({nm, ".gnt_idx"},   32'(bus.gnt_idx),   32'(ei));
      chk({nm, ".gnt_vec"},   32'(bus.gnt_vec),   32'(evec));
      chk({nm, ".stall"},     32'(bus.stall),     32'(es));
      chk({nm, ".timeout"},   32'(bus.timeout),   32'(et));
   endtask

   initial begin
      int vcnt;
      logic seen;
      passed = 0;
      total  = 0;
      rst_n    = 1'b0;
      bus.en   = 1'b0;
      bus.req  = 8'h00;
      bus.done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // name, en, req, done | gnt_valid, gnt_idx, gnt_vec, stall, timeout (after the edge)
      add("t1_grant",    1, 8'h28, 0, 1, 3'd3, 8'h08, 1, 0);
      add("t1_done",     1, 8'h28, 1, 0, 3'd3, 8'h00, 1, 0);
      add("t1_idle",     1, 8'h28, 0, 0, 3'd3, 8'h00, 1, 0);
      add("t1_regrant",  1, 8'h28, 0, 1, 3'd3, 8'h08, 1, 0);
      add("t2_nopreempt",1, 8'h29, 0, 1, 3'd3, 8'h08, 1, 0);
      add("t2_done",     1, 8'h29, 1, 0, 3'd3, 8'h00, 1, 0);
      add("t2_idle",     1, 8'h29, 0, 0, 3'd3, 8'h00, 1, 0);
      add("t2_grant0",   1, 8'h29, 0, 1, 3'd0, 8'h01, 1, 0);
      add("t2_done0",    1, 8'h01, 1, 0, 3'd0, 8'h00, 1, 0);
      add("t2_quiet",    1, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0);
      add("t3_g1",       1, 8'h80, 0, 1, 3'd7, 8'h80, 1, 0);
      add("t3_g2",       1, 8'h80, 0, 1, 3'd7, 8'h80, 1, 0);
      add("t3_g3",       1, 8'h80, 0, 1, 3'd7, 8'h80, 1, 0);
      add("t3_g4",       1, 8'h80, 0, 1, 3'd7, 8'h80, 1, 0);
      add("t3_tmo_gap",  1, 8'h80, 0, 0, 3'd7, 8'h00, 1, 1);
      add("t3_idle",     1, 8'h80, 0, 0, 3'd7, 8'h00, 1, 0);
      add("t4_g1",       1, 8'h80, 0, 1, 3'd7, 8'h80, 1, 0);
      add("t4_g2",       1, 8'h80, 0, 1, 3'd7, 8'h80, 1, 0);
      add("t4_g3",       1, 8'h80, 0, 1, 3'd7, 8'h80, 1, 0);
      add("t4_g4",       1, 8'h80, 0, 1, 3'd7, 8'h80, 1, 0);
      add("t4_done_tmo", 1, 8'h80, 1, 0, 3'd7, 8'h00, 1, 0);
      add("t4_idle",     1, 8'h00, 0, 0, 3'd7, 8'h00, 0, 0);
      add("t5_grant2",   1, 8'h04, 0, 1, 3'd2, 8'h04, 1, 0);
      add("t5_en_abort", 0, 8'h04, 0, 0, 3'd2, 8'h00, 0, 0);
      add("t5_en_x",     0, 8'hxx, 1'bx, 0, 3'd2, 8'h00, 0, 0);
      add("t5_regrant2", 1, 8'h04, 0, 1, 3'd2, 8'h04, 1, 0);
      add("t5_withdraw", 1, 8'h00, 0, 0, 3'd2, 8'h00, 1, 0);
      add("t5_idle",     1, 8'h00, 0, 0, 3'd2, 8'h00, 0, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         bus.en   = tbl[i].en;
         bus.req  = tbl[i].req;
         bus.done = tbl[i].done;
         @(posedge clk);
         #1;
         check_outs(tbl[i].nm, tbl[i].ev, tbl[i].ei, tbl[i].evec, tbl[i].es, tbl[i].et);
      end

      // Asynchronous reset in the middle of a grant.
      @(negedge clk);
      bus.en   = 1'b1;
      bus.req  = 8'h04;
      bus.done = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_pre.gnt_valid", 32'(bus.gnt_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async.gnt_valid", 32'(bus.gnt_valid), 32'd0);
      chk("t6_async.gnt_idx",   32'(bus.gnt_idx),   32'd0);
      chk("t6_async.gnt_vec",   32'(bus.gnt_vec),   32'd0);
      chk("t6_async.timeout",   32'(bus.timeout),   32'd0);
      @(negedge clk);
      bus.req = 8'h00;
      rst_n   = 1'b1;
      #1;
      chk("t6_rel.stall", 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1;
      check_outs("t6_idle", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

      // Grant duration after reset: exactly TIMEOUT cycles of ownership, then one timeout pulse.
      @(negedge clk);
      bus.req = 8'h80;
      vcnt = 0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.gnt_valid) vcnt++;
         if (bus.timeout) begin
            seen = 1'b1;
            break;
         end
      end
      chk("t7_tmo_seen",    32'(seen), 32'd1);
      chk("t7_valid_cycles", 32'(vcnt), 32'd4);
      @(posedge clk);
      #1;
      chk("t7_tmo_pulse_end", 32'(bus.timeout), 32'd0);
      @(negedge clk);
      bus.en  = 1'b0;
      bus.req = 8'h00;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
